mc_main_ctrl: RTL
=================

Name: mc_main_ctrl

Overview:
- Multicycle MIPS main control FSM. Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath strobe.
- Produces the 2-bit ALU control class on `alu_ctrl_op`, which the ALU control decoder consumes together with `funct`.
- Owns the memory handshake (`mem_ready`) and a wait-timeout watchdog.

Parameters:
- WAIT_LIMIT, 16, max cycles a memory state waits for `mem_ready` before bus error (1..255)
- CNT_W, 8, width of the wait counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if `zero`
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  regfile write data: 0=ALUOut, 1=MDR
- reg_dst  out  1  write register: 0=rt, 1=rd
- reg_write  out  1  regfile write enable
- alu_src_a  out  1  0=PC, 1=regA
- alu_src_b  out  2  00=regB, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_ctrl_op  out  2  00=ADD, 01=SUB, 10=RTYPE (use funct), 11 never driven
- illegal_instr  out  1  one-cycle pulse on unsupported opcode
- bus_err  out  1  sticky memory-timeout flag
- state_o  out  4  current state (debug)

Behaviour:
- Clock/reset: one clock; `rst` is synchronous and active-high.
- Reset:
  - State goes to FETCH(0) and the wait counter clears to 0.
  - `bus_err` = 0. `illegal_instr` = 0.
  - While `rst` is high, every strobe (`pc_write`, `pc_write_cond`, `mem_read`, `mem_write`, `ir_write`, `reg_write`) is forced to 0.
  - Mux selects are 0 except the FETCH values below.
  - Reset mid-instruction aborts it; no write of any kind occurs in the reset cycle.
- Output style: Moore outputs decoded from state. Exception: strobes in memory states are gated by `mem_ready`.
- States and outputs (unlisted outputs are 0):
  - FETCH(0): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctrl_op`=00, `pc_source`=00. `ir_write` and `pc_write` = `mem_ready`. Stay until `mem_ready`, then go to DECODE.
  - DECODE(1): `alu_src_a`=0, `alu_src_b`=11, `alu_ctrl_op`=00 (branch target into ALUOut). Next state by opcode:
    - 0x23 lw / 0x2B sw -> MEMADDR(2)
    - 0x00 R-type -> EXEC(6)
    - 0x04 beq -> BRANCH(8)
    - 0x02 j -> JUMP(9)
    - 0x08 addi -> ADDIEX(10)
    - any other opcode -> pulse `illegal_instr`, go to FETCH
  - MEMADDR(2): `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl_op`=00. Go to MEMRD(3) if lw, else MEMWR(5).
  - MEMRD(3): `mem_read`=1, `iord`=1. Wait for `mem_ready`, then go to MEMWB(4).
  - MEMWB(4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Go to FETCH.
  - MEMWR(5): `mem_write`=1, `iord`=1. Wait for `mem_ready`, then go to FETCH.
  - EXEC(6): `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl_op`=10. Go to RWB(7).
  - RWB(7): `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Go to FETCH.
  - BRANCH(8): `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl_op`=01, `pc_write_cond`=1, `pc_source`=01. Go to FETCH.
  - JUMP(9): `pc_write`=1, `pc_source`=10. Go to FETCH.
  - ADDIEX(10): `alu_src_a`=1, `alu_src_b`=10, `alu_ctrl_op`=00. Go to ADDIWB(11).
  - ADDIWB(11): `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Go to FETCH.
  - HALT(12): all strobes 0. Leave only via `rst`.
  - Codes 13-15: unreachable; if entered, go to FETCH next cycle.
- Wait counter (memory states 0, 3, 5):
  - Increments on each cycle with `mem_ready`=0.
  - Clears on any state change.
  - When the counter equals WAIT_LIMIT-1 and `mem_ready`=0: next state is HALT and `bus_err` is set (sticky until `rst`). No strobe is asserted in that cycle.
  - `mem_ready`=1 on that same cycle wins: the access completes normally.
- `mem_ready` outside memory states is ignored.
- `opcode` is sampled only in DECODE and MEMADDR; IR is stable from DECODE through the end of the instruction.
- Minimum cycles per instruction (`mem_ready`=1 immediately): lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

Test Plan:
- Reset/FETCH: assert `rst` 2 cycles with `mem_ready`=1 -> `state_o`=0 and all strobes 0 during reset; first post-reset cycle gives `mem_read`=1, `ir_write`=1, `pc_write`=1, `alu_src_b`=01.
- lw with zero wait, `opcode`=0x23 -> state sequence 0,1,2,3,4,0; `iord`=1 and `mem_read`=1 in state 3; `reg_write`=1 with `mem_to_reg`=1 in state 4; total 5 cycles.
- R-type and beq:
  - `opcode`=0x00 -> `alu_ctrl_op`=10 in state 6, `reg_write`=1 with `reg_dst`=1 in state 7.
  - `opcode`=0x04 with `zero`=1 -> state 8 has `alu_ctrl_op`=01, `pc_write_cond`=1, `pc_source`=01.
- Wait states: sw with `mem_ready` held low 3 cycles in state 5 -> `mem_write` stays 1 for 4 cycles, then FETCH.
- Timeout: WAIT_LIMIT=4, `mem_ready` never asserted in FETCH -> after 4 cycles, `state_o`=12 and `bus_err`=1; `bus_err` stays 1 until `rst`, then clears.
- Illegal opcode and mid-instruction reset:
  - `opcode`=0x3F -> `illegal_instr` high exactly 1 cycle in DECODE, then FETCH.
  - `rst` asserted in state 4 -> no `reg_write` that cycle; `state_o`=0 next cycle.

Source files
------------

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main control FSM.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath strobe. Memory states wait on mem_ready under a
// watchdog; a wait that runs out parks the FSM in HALT with a sticky bus_err.
module mc_main_ctrl #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_source,
   output logic [1:0] alu_ctrl_op,
   output logic       illegal_instr,
   output logic       bus_err,
   output logic [3:0] state_o
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADDR = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXEC    = 4'd6;
   localparam logic [3:0] S_RWB     = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_JUMP    = 4'd9;
   localparam logic [3:0] S_ADDIEX  = 4'd10;
   localparam logic [3:0] S_ADDIWB  = 4'd11;
   localparam logic [3:0] S_HALT    = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

   logic [3:0]       r_state;
   logic [3:0]       w_state_next;
   logic [CNT_W-1:0] r_wait_cnt;
   logic [CNT_W-1:0] w_wait_cnt_next;
   logic             r_bus_err;
   logic             w_mem_state;
   logic             w_timeout;
   logic             w_op_legal;
   logic [3:0]       w_dec_state;

   // States that issue a memory access and therefore wait on mem_ready.
   assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) ||
                        (r_state == S_MEMWR);

   // Last permitted wait cycle with no completion; mem_ready on this cycle wins.
   assign w_timeout = w_mem_state && !mem_ready && (r_wait_cnt == CNT_LAST);

   assign w_op_legal = (opcode == OP_LW)    || (opcode == OP_SW)  ||
                       (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                       (opcode == OP_J)     || (opcode == OP_ADDI);

   // State register, wait counter and sticky bus error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_wait_cnt <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Next-state selection; opcode is only consulted in DECODE and MEMADDR.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FETCH: begin
            if (mem_ready)      w_state_next = S_DECODE;
            else if (w_timeout) w_state_next = S_HALT;
         end
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: w_state_next = S_MEMADDR;
               OP_RTYPE:     w_state_next = S_EXEC;
               OP_BEQ:       w_state_next = S_BRANCH;
               OP_J:         w_state_next = S_JUMP;
               OP_ADDI:      w_state_next = S_ADDIEX;
               default:      w_state_next = S_FETCH;
            endcase
         end
         S_MEMADDR: w_state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD: begin
            if (mem_ready)      w_state_next = S_MEMWB;
            else if (w_timeout) w_state_next = S_HALT;
         end
         S_MEMWR: begin
            if (mem_ready)      w_state_next = S_FETCH;
            else if (w_timeout) w_state_next = S_HALT;
         end
         S_EXEC:   w_state_next = S_RWB;
         S_ADDIEX: w_state_next = S_ADDIWB;
         S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: w_state_next = S_FETCH;
         S_HALT:   w_state_next = S_HALT;
         default:  w_state_next = S_FETCH;
      endcase
   end

   // Wait counter: clears on any state change, counts unanswered memory cycles.
   always_comb begin
      w_wait_cnt_next = r_wait_cnt;
      if (w_state_next != r_state) begin
         w_wait_cnt_next = '0;
      end else if (w_mem_state && !mem_ready) begin
         w_wait_cnt_next = r_wait_cnt + 1'b1;
      end
   end

   // Moore output decode; reset decodes as FETCH so muxes show fetch selects.
   assign w_dec_state = rst ? S_FETCH : r_state;

   // Output decode with mem_ready gating and reset/timeout strobe suppression.
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_source     = 2'b00;
      alu_ctrl_op   = 2'b00;
      illegal_instr = 1'b0;
      case (w_dec_state)
         S_FETCH: begin
            mem_read  = !w_timeout;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            alu_src_b = 2'b01;
         end
         S_DECODE: begin
            alu_src_b     = 2'b11;
            illegal_instr = !w_op_legal;
         end
         S_MEMADDR, S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = !w_timeout;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = !w_timeout;
            iord      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a   = 1'b1;
            alu_ctrl_op = 2'b10;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_ctrl_op   = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDIWB: reg_write = 1'b1;
         default: ;
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         illegal_instr = 1'b0;
      end
   end

   assign bus_err = r_bus_err;
   assign state_o = r_state;

endmodule
